mfcc_feature_buffer: RTL and testbench
======================================

# mfcc_feature_buffer

Collects the MFCC coefficient stream from the MFCC accelerator (`mfcc_out`/`mfcc_valid`) into frames. Keeps a sliding window of the most recent NUM_FRAMES complete frames. On request, streams that window out oldest-first over a valid/ready interface to the downstream keyword classifier. The MFCC pipeline has no backpressure, so the buffer never stalls its input; it drops whole frames instead when readout would otherwise be corrupted.

## Interface
- COEF_W, 32, coefficient width (matches `mfcc_out`)
- MAX_COEFFS, 16, max coefficients per frame (power of two)
- NUM_FRAMES, 16, frames in the classifier window; storage is (NUM_FRAMES+1)*MAX_COEFFS words

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mfcc_in  in  COEF_W  coefficient from the MFCC accelerator
- mfcc_valid  in  1  `mfcc_in` valid this cycle
- num_mfcc_coeffs  in  8  coefficients per frame (N)
- flush  in  1  synchronous clear of the window and all state
- feat_start  in  1  request readout of the current window
- feat_out  out  COEF_W  window word
- feat_valid  out  1  `feat_out` valid
- feat_ready  in  1  consumer accepts `feat_out`
- feat_last  out  1  final word of the window
- window_ready  out  1  NUM_FRAMES complete frames are stored
- overrun  out  1  sticky: at least one frame was dropped

## Operation
- Reset (async) or flush (sync) clears all state:
  - write slot = 0, coefficient index = 0, frames_stored = 0
  - drop flag and overrun cleared; FSM goes to IDLE
  - all outputs 0
- Flush has priority over every other event in the same cycle; any coefficient presented that cycle is discarded.
- N latch:
  - N is latched from `num_mfcc_coeffs` at the first coefficient after reset/flush, clamped to [1, MAX_COEFFS].
  - Later changes to `num_mfcc_coeffs` are ignored until the next flush.
- Write path:
  - Each `mfcc_valid` writes to address slot*MAX_COEFFS+idx and increments idx.
  - At idx==N-1 the frame is complete: idx returns to 0, the write slot advances mod NUM_FRAMES+1, and frames_stored increments, saturating at NUM_FRAMES.
  - The write slot is never part of the readable window.
- window_ready = (frames_stored == NUM_FRAMES).
- FSM IDLE -> READ:
  - Taken when feat_start=1 and window_ready=1.
  - The base slot is latched as the oldest complete frame, (write slot + 1) mod (NUM_FRAMES+1), using pre-edge pointer state.
  - feat_start is ignored in READ or when window_ready=0.
- READ:
  - Emits NUM_FRAMES*N words in order: frame base..base+NUM_FRAMES-1 (slot wrap mod NUM_FRAMES+1), coefficients 0..N-1 within each frame.
  - feat_last is high with the final word.
  - READ -> IDLE on the handshake (feat_valid & feat_ready) of the final word.
- Overrun protection:
  - Counts frame completions during READ, including one that completes on the same edge as start acceptance.
  - If a frame's first coefficient (idx 0) arrives in READ after at least one such completion, the drop flag is set for that whole frame: its N coefficients advance idx but are not written, the slot does not advance, frames_stored is unchanged, and overrun is set.
  - The drop decision is made only at idx 0; a frame started in IDLE is always kept.

## Timing
- Read memory: registered, 1-cycle latency, plus an output register or skid buffer.
- The first feat_valid is high 2 cycles after the edge that samples the accepted feat_start.
- Throughput is 1 word/cycle while feat_ready=1.
- While feat_valid=1 and feat_ready=0: feat_out, feat_last and feat_valid are held stable and no word is lost or duplicated.
- A write issued on a given edge is readable from the next cycle.
- There are no read/write conflicts on the same address: the write slot is never in the latched window.
- feat_valid and feat_last go low in the cycle after the final handshake, or after flush.
- window_ready and overrun update on the edge of the causing event.

## Test plan
- Reset check: assert rst_n=0 mid-readout -> all outputs 0 immediately. Then, with NUM_FRAMES=4, MAX_COEFFS=16, N=13 and coefficients of value frame*256+idx, after 4 frames window_ready=1 exactly on the 52nd coefficient edge.
- Basic readout: feat_start with feat_ready=1 -> first word 0x000 two cycles later, then 52 consecutive words 0x000..0x30C in order, feat_last on 0x30C, then IDLE.
- Sliding window: stream 6 frames (0..5), then start -> readout begins with frame 2 (0x200) and ends with 0x50C.
- Backpressure: toggle feat_ready pseudo-randomly -> exact 52-word sequence, values stable while stalled, one feat_last.
- Overrun: start readout with feat_ready=0 while frames 4 and 5 arrive -> frame 4 kept, frame 5 dropped, overrun=1; the next readout shows frames 1..4.
- Flush/clamp: flush during READ -> feat_valid=0 next cycle, window_ready=0. Then num_mfcc_coeffs=40 -> N clamps to 16 (64-word window); num_mfcc_coeffs=0 -> N=1.

Source files
------------

// File: rtl/mfcc_feature_buffer.sv
// rtl/mfcc_feature_buffer.sv - sliding window of MFCC frames with oldest-first streamed readout
module mfcc_feature_buffer #(
  parameter int COEF_W     = 32,
  parameter int MAX_COEFFS = 16,
  parameter int NUM_FRAMES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [COEF_W-1:0] mfcc_in_i,
  input  logic              mfcc_valid_i,
  input  logic [7:0]        num_mfcc_coeffs_i,
  input  logic              flush_i,
  input  logic              feat_start_i,
  output logic [COEF_W-1:0] feat_out_o,
  output logic              feat_valid_o,
  input  logic              feat_ready_i,
  output logic              feat_last_o,
  output logic              window_ready_o,
  output logic              overrun_o
);

  // One spare slot beyond the window holds the frame being written.
  localparam int SLOTS = NUM_FRAMES + 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int IW    = $clog2(MAX_COEFFS);
  localparam int NW    = IW + 1;
  localparam int FW    = $clog2(NUM_FRAMES + 1);
  localparam int AW    = SW + IW;
  localparam int DEPTH = SLOTS * MAX_COEFFS;

  localparam logic [SW-1:0] LAST_SLOT  = SW'(SLOTS - 1);
  localparam logic [FW-1:0] FULL       = FW'(NUM_FRAMES);
  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
  localparam logic [NW-1:0] N_MAX      = NW'(MAX_COEFFS);

  typedef enum logic {IDLE, READ} state_e;

  state_e state_q, state_d;

  // Write side
  logic [SW-1:0] wslot_q, wslot_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] frames_q, frames_d;
  logic [NW-1:0] n_q, n_d;
  logic          n_valid_q, n_valid_d;
  logic          drop_q, drop_d;
  logic          seen_q, seen_d;
  logic          overrun_q, overrun_d;

  // Read side: issue counters, memory-read stage, output stage
  logic [SW-1:0]     rs_q, rs_d;
  logic [IW-1:0]     rc_q, rc_d;
  logic [FW-1:0]     rf_q, rf_d;
  logic              iss_done_q, iss_done_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_last_q, s1_last_d;
  logic [COEF_W-1:0] s1_data_q;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [COEF_W-1:0] out_data_q, out_data_d;

  logic [COEF_W-1:0] mem_q [DEPTH];

  logic [NW-1:0] n_clamp;
  logic [NW-1:0] n_cur;
  logic          idx_zero;
  logic          drop_cur;
  logic          frame_end;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          start_acc;
  logic          adv_out;
  logic          s1_load;
  logic          issue;
  logic          iss_last;
  logic          out_hs_last;

  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + SW'(1);
  endfunction

  // Clamp the requested coefficient count into [1, MAX_COEFFS]
  always_comb begin
    n_clamp = NW'(1);
    if (num_mfcc_coeffs_i == 8'd0) begin
      n_clamp = NW'(1);
    end else if (int'(num_mfcc_coeffs_i) > MAX_COEFFS) begin
      n_clamp = N_MAX;
    end else begin
      n_clamp = NW'(num_mfcc_coeffs_i);
    end
  end

  assign n_cur     = n_valid_q ? n_q : n_clamp;
  assign idx_zero  = (idx_q == '0);
  // Keep/drop is decided once, on a frame's first coefficient.
  assign drop_cur  = idx_zero ? ((state_q == READ) && seen_q) : drop_q;
  assign frame_end = ({1'b0, idx_q} == n_cur - NW'(1));
  assign wr_en     = mfcc_valid_i && !flush_i && !drop_cur;
  assign wr_addr   = {wslot_q, idx_q};
  assign rd_addr   = {rs_q, rc_q};

  assign window_ready_o = (frames_q == FULL);
  assign start_acc      = (state_q == IDLE) && feat_start_i && window_ready_o;
  assign adv_out        = !out_valid_q || feat_ready_i;
  assign s1_load        = !s1_valid_q || adv_out;
  assign issue          = (state_q == READ) && !iss_done_q && s1_load;
  assign iss_last       = (rf_q == LAST_FRAME) && ({1'b0, rc_q} == n_q - NW'(1));
  assign out_hs_last    = out_valid_q && feat_ready_i && out_last_q;

  assign feat_out_o   = out_data_q;
  assign feat_valid_o = out_valid_q;
  assign feat_last_o  = out_last_q;
  assign overrun_o    = overrun_q;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter READ on an accepted start, leave on the final handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_acc) state_d = READ;
      READ:    if (out_hs_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Datapath next state for the write pointers, overrun tracking and read pipeline
  always_comb begin
    wslot_d     = wslot_q;
    idx_d       = idx_q;
    frames_d    = frames_q;
    n_d         = n_q;
    n_valid_d   = n_valid_q;
    drop_d      = drop_q;
    seen_d      = seen_q;
    overrun_d   = overrun_q;
    rs_d        = rs_q;
    rc_d        = rc_q;
    rf_d        = rf_q;
    iss_done_d  = iss_done_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    // Readout begins at the oldest complete frame, just past the write slot.
    if (start_acc) begin
      rs_d       = next_slot(wslot_q);
      rc_d       = '0;
      rf_d       = '0;
      iss_done_d = 1'b0;
      seen_d     = 1'b0;
    end

    if (adv_out) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      out_data_d  = s1_valid_q ? s1_data_q : '0;
    end

    if (s1_load) begin
      s1_valid_d = issue;
      s1_last_d  = issue && iss_last;
    end

    if (issue) begin
      if (iss_last) iss_done_d = 1'b1;
      if ({1'b0, rc_q} == n_q - NW'(1)) begin
        rc_d = '0;
        rf_d = rf_q + FW'(1);
        rs_d = next_slot(rs_q);
      end else begin
        rc_d = rc_q + IW'(1);
      end
    end

    if (mfcc_valid_i) begin
      if (!n_valid_q) begin
        n_valid_d = 1'b1;
        n_d       = n_clamp;
      end
      if (idx_zero) begin
        drop_d = drop_cur;
        if (drop_cur) overrun_d = 1'b1;
      end
      if (frame_end) begin
        idx_d = '0;
        if (!drop_cur) begin
          wslot_d  = next_slot(wslot_q);
          frames_d = (frames_q == FULL) ? FULL : frames_q + FW'(1);
          // A completion during readout means the next frame would land in the window.
          if ((state_q == READ) || start_acc) seen_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    if (flush_i) begin
      wslot_d     = '0;
      idx_d       = '0;
      frames_d    = '0;
      n_d         = '0;
      n_valid_d   = 1'b0;
      drop_d      = 1'b0;
      seen_d      = 1'b0;
      overrun_d   = 1'b0;
      rs_d        = '0;
      rc_d        = '0;
      rf_d        = '0;
      iss_done_d  = 1'b0;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wslot_q     <= '0;
      idx_q       <= '0;
      frames_q    <= '0;
      n_q         <= '0;
      n_valid_q   <= 1'b0;
      drop_q      <= 1'b0;
      seen_q      <= 1'b0;
      overrun_q   <= 1'b0;
      rs_q        <= '0;
      rc_q        <= '0;
      rf_q        <= '0;
      iss_done_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wslot_q     <= wslot_d;
      idx_q       <= idx_d;
      frames_q    <= frames_d;
      n_q         <= n_d;
      n_valid_q   <= n_valid_d;
      drop_q      <= drop_d;
      seen_q      <= seen_d;
      overrun_q   <= overrun_d;
      rs_q        <= rs_d;
      rc_q        <= rc_d;
      rf_q        <= rf_d;
      iss_done_q  <= iss_done_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Frame storage: coefficient writes and the registered read feeding the output stage
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_addr] <= mfcc_in_i;
    if (s1_load) s1_data_q <= mem_q[rd_addr];
  end

endmodule

// File: tb/tb_mfcc_feature_buffer.sv
// tb/tb_mfcc_feature_buffer.sv - scoreboard bench for mfcc_feature_buffer
module tb_mfcc_feature_buffer;

  localparam int COEF_W = 32;
  localparam int MAXC   = 16;
  localparam int NF     = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [COEF_W-1:0] mfcc_in_i = '0;
  logic              mfcc_valid_i = 1'b0;
  logic [7:0]        num_mfcc_coeffs_i = 8'd13;
  logic              flush_i = 1'b0;
  logic              feat_start_i = 1'b0;
  logic [COEF_W-1:0] feat_out_o;
  logic              feat_valid_o;
  logic              feat_ready_i = 1'b1;
  logic              feat_last_o;
  logic              window_ready_o;
  logic              overrun_o;

  mfcc_feature_buffer #(.COEF_W(COEF_W), .MAX_COEFFS(MAXC), .NUM_FRAMES(NF)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mfcc_in_i(mfcc_in_i), .mfcc_valid_i(mfcc_valid_i),
    .num_mfcc_coeffs_i(num_mfcc_coeffs_i), .flush_i(flush_i), .feat_start_i(feat_start_i),
    .feat_out_o(feat_out_o), .feat_valid_o(feat_valid_o), .feat_ready_i(feat_ready_i),
    .feat_last_o(feat_last_o), .window_ready_o(window_ready_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  logic [COEF_W:0] sb [$];
  logic            stall_prev = 1'b0;
  logic [COEF_W:0] stall_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input int f, input int n);
    for (int i = 0; i < n; i++) begin
      mfcc_valid_i = 1'b1;
      mfcc_in_i    = COEF_W'(f * 256 + i);
      tick();
    end
    mfcc_valid_i = 1'b0;
  endtask

  task automatic push_window(input int f0, input int n);
    for (int f = f0; f < f0 + NF; f++)
      for (int i = 0; i < n; i++)
        sb.push_back({(f == f0 + NF - 1) && (i == n - 1), COEF_W'(f * 256 + i)});
  endtask

  task automatic do_start();
    feat_start_i = 1'b1;
    tick();
    feat_start_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((sb.size() != 0) && (cyc < 3000)) begin
      tick();
      cyc++;
    end
    check({name, "_timeout"}, 64'(sb.size()), 64'd0);
    sb.delete();
    tick();
    check({name, "_idle"}, {62'd0, feat_valid_o, feat_last_o}, 64'd0);
  endtask

  // Monitor: pop expected words on each handshake and hold-check stalled words
  initial begin : monitor
    logic [COEF_W:0] exp_w;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(feat_valid_o), 64'd1);
          check("stall_word", 64'({feat_last_o, feat_out_o}), 64'(stall_word));
        end
        if (feat_valid_o && feat_ready_i) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %0h expected none", {feat_last_o, feat_out_o});
          end else begin
            exp_w = sb.pop_front();
            check("word", 64'({feat_last_o, feat_out_o}), 64'(exp_w));
          end
        end
        stall_prev = feat_valid_o && !feat_ready_i;
        stall_word = {feat_last_o, feat_out_o};
      end
    end
  end

  initial begin : stimulus
    tick();
    tick();
    check("reset_outputs", 64'({feat_valid_o, feat_last_o, window_ready_o, overrun_o, feat_out_o}), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Fill four 13-coefficient frames; window_ready must rise on the 52nd edge.
    for (int f = 0; f < 3; f++) send_frame(f, 13);
    for (int i = 0; i < 13; i++) begin
      mfcc_valid_i = 1'b1;
      mfcc_in_i    = COEF_W'(3 * 256 + i);
      tick();
      if (i == 11) check("window_ready_51", 64'(window_ready_o), 64'd0);
      if (i == 12) check("window_ready_52", 64'(window_ready_o), 64'd1);
    end
    mfcc_valid_i = 1'b0;

    // Basic readout with latency check.
    push_window(0, 13);
    do_start();
    check("latency_e0", 64'(feat_valid_o), 64'd0);
    tick();
    check("latency_e1", 64'(feat_valid_o), 64'd0);
    tick();
    check("latency_e2", 64'({feat_valid_o, feat_out_o}), {31'd0, 1'b1, 32'h0});
    wait_drain("basic");

    // Sliding window: two more frames move the window to frames 2..5.
    send_frame(4, 13);
    send_frame(5, 13);
    push_window(2, 13);
    do_start();
    wait_drain("sliding");

    // Backpressure: pseudo-random ready.
    push_window(2, 13);
    do_start();
    for (int c = 0; (c < 1000) && (sb.size() != 0); c++) begin
      feat_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    feat_ready_i = 1'b1;
    wait_drain("backpressure");

    // Overrun: frame 6 kept, frame 7 dropped while readout is stalled.
    feat_ready_i = 1'b0;
    push_window(2, 13);
    do_start();
    send_frame(6, 13);
    check("overrun_after_kept", 64'(overrun_o), 64'd0);
    send_frame(7, 13);
    check("overrun_after_drop", 64'({window_ready_o, overrun_o}), 64'd3);
    feat_ready_i = 1'b1;
    wait_drain("overrun_read");
    push_window(3, 13);
    do_start();
    wait_drain("after_overrun");

    // Asynchronous reset in the middle of a readout.
    push_window(3, 13);
    do_start();
    for (int c = 0; c < 6; c++) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("reset_mid_read", 64'({feat_valid_o, feat_last_o, window_ready_o, overrun_o, feat_out_o}), 64'd0);
    sb.delete();
    tick();
    rst_ni = 1'b1;
    tick();

    // Flush during readout, with a coefficient presented in the flush cycle.
    for (int f = 0; f < 4; f++) send_frame(f, 13);
    push_window(0, 13);
    do_start();
    for (int c = 0; c < 8; c++) tick();
    flush_i           = 1'b1;
    mfcc_valid_i      = 1'b1;
    mfcc_in_i         = 32'hDEAD;
    num_mfcc_coeffs_i = 8'd40;
    tick();
    flush_i      = 1'b0;
    mfcc_valid_i = 1'b0;
    check("flush_outputs", 64'({feat_valid_o, window_ready_o, overrun_o}), 64'd0);
    sb.delete();
    tick();

    // Clamp high: N=16, 64-word window.
    for (int f = 0; f < 4; f++) send_frame(f, 16);
    check("clamp16_ready", 64'(window_ready_o), 64'd1);
    push_window(0, 16);
    do_start();
    wait_drain("clamp16");

    // Clamp low: N=1, later num changes ignored.
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    num_mfcc_coeffs_i = 8'd0;
    send_frame(0, 1);
    num_mfcc_coeffs_i = 8'd5;
    for (int f = 1; f < 4; f++) send_frame(f, 1);
    check("clamp1_ready", 64'(window_ready_o), 64'd1);
    push_window(0, 1);
    do_start();
    wait_drain("clamp1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
